// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// requests onto a single 8-bit RAM/IO port, assembling reads and splitting writes.
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h00030000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rob_clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic        src_lsb_q, src_lsb_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;

    logic [31:0] mem_a_d;
    logic [7:0]  mem_dout_d;
    logic        mem_wr_d;
    logic        if_done_d, lsb_done_d;
    logic [31:0] if_data_d, lsb_rdata_d;

    logic [2:0]  lsb_n;
    logic [31:0] beat_addr;
    logic [31:0] rd_merge;
    logic        lsb_io_stall, cur_io_stall, can_accept;

    assign lsb_n        = (lsb_len == 2'd0) ? 3'd1 : (lsb_len == 2'd1) ? 3'd2 : 3'd4;
    assign beat_addr    = addr_q + {29'd0, cnt_q};
    // In READ, cnt_q counts edges since acceptance; byte cnt_q-2 arrives on mem_din now.
    assign rd_merge     = buf_q | ({24'd0, mem_din} << {cnt_q - 3'd2, 3'b000});
    assign lsb_io_stall = (lsb_addr >= IO_BASE) && io_buffer_full;
    assign cur_io_stall = (addr_q >= IO_BASE) && io_buffer_full;
    // A done pulse blocks acceptance so the still-held request is not taken twice.
    assign can_accept   = !rob_clear && !if_done && !lsb_done && (if_req || lsb_req);

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        src_lsb_d   = src_lsb_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a;
        mem_dout_d  = mem_dout;
        mem_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        if_data_d   = if_data;
        lsb_rdata_d = lsb_rdata;

        unique case (state_q)
            IDLE: begin
                if (can_accept) begin
                    src_lsb_d = lsb_req;
                    buf_d     = '0;
                    cnt_d     = 3'd1;
                    if (lsb_req) begin
                        addr_d  = lsb_addr;
                        len_d   = lsb_n;
                        wdata_d = lsb_wdata;
                    end else begin
                        addr_d  = if_addr;
                        len_d   = 3'd4;
                    end
                    if (lsb_req && lsb_wr) begin
                        state_d = WRITE;
                        if (lsb_io_stall) begin
                            cnt_d = 3'd0;
                        end else begin
                            mem_wr_d   = 1'b1;
                            mem_a_d    = lsb_addr;
                            mem_dout_d = lsb_wdata[7:0];
                        end
                    end else begin
                        state_d = READ;
                        mem_a_d = lsb_req ? lsb_addr : if_addr;
                    end
                end
            end

            READ: begin
                if (rob_clear) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < len_q) mem_a_d = beat_addr;
                    if (cnt_q >= 3'd2) buf_d = rd_merge;
                    if (cnt_q == len_q + 3'd1) begin
                        state_d = IDLE;
                        if (src_lsb_q) begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = rd_merge;
                        end else begin
                            if_done_d   = 1'b1;
                            if_data_d   = rd_merge;
                        end
                    end
                end
            end

            WRITE: begin
                // Committed stores ignore rob_clear; only a full I/O buffer can stall a beat.
                if (cnt_q == len_q) begin
                    state_d    = IDLE;
                    lsb_done_d = 1'b1;
                end else if (!cur_io_stall) begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = beat_addr;
                    mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d      = cnt_q + 3'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            src_lsb_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= '0;
            lsb_rdata <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            src_lsb_q <= src_lsb_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            mem_a     <= mem_a_d;
            mem_dout  <= mem_dout_d;
            mem_wr    <= mem_wr_d;
            if_done   <= if_done_d;
            lsb_done  <= lsb_done_d;
            if_data   <= if_data_d;
            lsb_rdata <= lsb_rdata_d;
        end
    end
endmodule
